bus_source_reader: RTL

Sequencing reader for the shared CPU datapath bus. It accepts read requests naming a source register index and drives that source's one-hot bus-out enable for a programmable number of cycles. It samples the bus value and returns it on a valid/ready response port. It is the read end of the bus: registers capture from the bus on `enable`, and this block arbitrates which source drives the bus and collects the result for the control unit and debug port.

---
 rtl/bus_source_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bus_source_reader.sv
// +--------------------------------------------------------------------------+
// | bus_source_reader                                                        |
// | Drives one source's bus-out enable, samples the bus, returns the value.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bus_source_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SOURCES = 24,
  parameter int SEL_WIDTH   = 5,
  parameter int SETTLE      = 0
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEL_WIDTH-1:0]   req_sel,
  output logic [NUM_SOURCES-1:0] src_out,
  input  logic [DATA_WIDTH-1:0]  BusMuxOut,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_err,
  output logic [15:0]            xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [SEL_WIDTH:0] c_num_src = (SEL_WIDTH+1)'(NUM_SOURCES);
  localparam logic [3:0]         c_settle  = 4'(SETTLE);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic [NUM_SOURCES-1:0] r_src, w_src_nxt;
  logic [DATA_WIDTH-1:0]  r_data, w_data_nxt;
  logic                   r_err, w_err_nxt;
  logic [15:0]            r_count, w_count_nxt;
  logic [NUM_SOURCES-1:0] w_onehot;
  logic                   w_in_range;

  assign w_in_range = ({1'b0, req_sel} < c_num_src);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_onehot[i] = (req_sel == SEL_WIDTH'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_src_nxt   = r_src;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        w_src_nxt = '0;
        if (req_valid) begin
          if (w_in_range) begin
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = c_settle;
            w_src_nxt   = w_onehot;
          end else begin
            w_state_nxt = S_RESP;
            w_data_nxt  = '0;
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        // Enables drop on the same edge that samples, so the bus is never left driven in RESP.
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_data_nxt  = BusMuxOut;
          w_err_nxt   = 1'b0;
          w_src_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_src_nxt = '0;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = r_count + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_src_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_src   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_src   <= w_src_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign src_out    = r_src;
  assign rsp_data   = r_data;
  assign rsp_err    = r_err;
  assign xfer_count = r_count;

endmodule

`default_nettype wire
